// File: rtl/approx_mult_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier built on one shared HxH multiplier.
// Exact mode sums all four partial products; approximate mode skips LL and truncates the rest.
module approx_mult_seq #(
    parameter int WIDTH = 32,
    parameter int TRUNC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 out_mode
);

    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0] TRUNC_MASK = {WIDTH{1'b1}} << TRUNC;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 mode_q, mode_d;
    logic [1:0]           step_q, step_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    logic [1:0]           sel;
    logic                 last;
    logic [H-1:0]         mul_a, mul_b;
    logic [WIDTH-1:0]     prod, pp;
    logic [2*WIDTH-1:0]   weighted;

    // sel encodes the partial product: 0 = LL, 1 = HL, 2 = LH, 3 = HH; approx mode starts at HL.
    assign sel   = step_q + {1'b0, mode_q};
    assign last  = (sel == 2'd3);
    assign mul_a = sel[0] ? a_q[WIDTH-1:H] : a_q[H-1:0];
    assign mul_b = sel[1] ? b_q[WIDTH-1:H] : b_q[H-1:0];
    assign prod  = {{H{1'b0}}, mul_a} * {{H{1'b0}}, mul_b};
    assign pp    = mode_q ? (prod & TRUNC_MASK) : prod;

    always_comb begin
        case (sel)
            2'd0:    weighted = {{WIDTH{1'b0}}, pp};
            2'd1,
            2'd2:    weighted = {{H{1'b0}}, pp, {H{1'b0}}};
            default: weighted = {pp, {WIDTH{1'b0}}};
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        step_d    = step_q;
        acc_d     = acc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_q + weighted;
                step_d = step_q + 2'd1;
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand registers are reset too; it costs little and keeps post-reset state deterministic.
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            step_q  <= '0;
            acc_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
        end
    end

    assign y        = acc_q;
    assign out_mode = mode_q;

endmodule

// File: tb/tb_approx_mult_seq.sv
// Directed bench for approx_mult_seq: results are queued at issue and compared when out_valid rises.
module tb_approx_mult_seq;

    localparam int W     = 32;
    localparam int TRUNC = 8;

    logic          clk = 1'b0;
    logic          rst, in_valid, mode, out_ready;
    logic [W-1:0]  a, b;
    logic          in_ready, out_valid, out_mode;
    logic [2*W-1:0] y;

    typedef struct {
        logic [63:0] y;
        logic        m;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    approx_mult_seq #(.WIDTH(W), .TRUNC(TRUNC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_mode(out_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] av, input logic [31:0] bv, input logic m);
        logic [63:0] hl, lh, hh, msk;
        if (!m) return {32'd0, av} * {32'd0, bv};
        msk = {64{1'b1}} << TRUNC;
        hl  = ({48'd0, av[31:16]} * {48'd0, bv[15:0]})  & msk;
        lh  = ({48'd0, av[15:0]}  * {48'd0, bv[31:16]}) & msk;
        hh  = ({48'd0, av[31:16]} * {48'd0, bv[31:16]}) & msk;
        return (hl << 16) + (lh << 16) + (hh << 32);
    endfunction

    // Issues one operation from IDLE and returns at the negedge after the accepting edge.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic m,
                            input logic [63:0] ey);
        exp_t e;
        @(negedge clk);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        a = av; b = bv; mode = m; in_valid = 1'b1;
        e.y = ey; e.m = m; e.lat = m ? 3 : 4;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~av; b = $urandom; mode = ~m;
    endtask

    task automatic wait_result(input string tag);
        int   lat = -1;
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            check({tag, "_busy_in_ready"}, {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_y"}, y, e.y);
        check({tag, "_out_mode"}, {63'd0, out_mode}, {63'd0, e.m});
    endtask

    task automatic release_op(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_rel_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_rel_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] ey;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; a = '0; b = '0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_y", y, 64'd0);
        check("rst_out_mode", {63'd0, out_mode}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        wait_result("exact_max");
        release_op("exact_max");
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFC_0000_0000);
        wait_result("approx_max");
        release_op("approx_max");
        start_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001);
        wait_result("ll_exact");
        release_op("ll_exact");
        start_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 64'd0);
        wait_result("ll_approx");
        release_op("ll_approx");
        start_op(32'h0002_0000, 32'h0003_0000, 1'b0, 64'h0000_0006_0000_0000);
        wait_result("trunc_exact");
        release_op("trunc_exact");
        start_op(32'h0002_0000, 32'h0003_0000, 1'b1, 64'd0);
        wait_result("trunc_approx");
        release_op("trunc_approx");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            start_op(ra, rb, i[0], model(ra, rb, i[0]));
            wait_result("random");
            release_op("random");
        end

        // Backpressure, then a request presented together with out_ready.
        ra = 32'hDEAD_BEEF; rb = 32'h0BAD_F00D;
        ey = model(ra, rb, 1'b0);
        start_op(ra, rb, 1'b0, ey);
        wait_result("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_y_stable", y, ey);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        begin
            exp_t e;
            ra = 32'hCAFE_1234; rb = 32'h8765_4321;
            out_ready = 1'b1; in_valid = 1'b1; a = ra; b = rb; mode = 1'b1;
            e.y = model(ra, rb, 1'b1); e.m = 1'b1; e.lat = 3;
            sb.push_back(e);
            @(negedge clk);
            check("b2b_idle_out_valid", {63'd0, out_valid}, 64'd0);
            check("b2b_idle_in_ready", {63'd0, in_ready}, 64'd1);
            out_ready = 1'b0;
            @(negedge clk);
            check("b2b_accepted", {63'd0, in_ready}, 64'd0);
            in_valid = 1'b0; a = ~ra; b = ~rb; mode = 1'b0;
            wait_result("b2b");
            release_op("b2b");
        end

        // Asynchronous reset in the second CALC cycle.
        start_op(32'h1111_2222, 32'h3333_4444, 1'b0, 64'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_y", y, 64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_no_valid", {63'd0, out_valid}, 64'd0);
        end
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080);
        wait_result("postrst");
        release_op("postrst");

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
